// File: rtl/adxl_seq_pkg.sv
// adxl_seq_pkg: sequencer states, ADXL345 register map, init table and SPI frame builder
package adxl_seq_pkg;
    typedef enum logic [2:0] {PWRUP, INIT_XFER, INIT_GAP, WAIT, RD_XFER, RD_CAP, RD_GAP, EMIT} seqState_t;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
    localparam int INIT_LEN = 3;
    localparam int RD_LEN   = 6;
    localparam logic [5:0] INIT_ADDR [INIT_LEN] = '{ADDR_DATA_FORMAT, ADDR_BW_RATE, ADDR_POWER_CTL};
    localparam logic [7:0] INIT_DATA [INIT_LEN] = '{8'h40, 8'h0A, 8'h08};
    localparam logic [5:0] RD_ADDR [RD_LEN] = '{ADDR_DATAX0, ADDR_DATAX1, ADDR_DATAY0,
                                                ADDR_DATAY1, ADDR_DATAZ0, ADDR_DATAZ1};

    function automatic logic [15:0] mkFrame(input logic rd, input logic [5:0] addr, input logic [7:0] data);
        return {rd, 1'b0, addr, data};
    endfunction
endpackage

// File: rtl/adxl_seq_timer.sv
// adxl_seq_timer: shared power-up/gap/timeout down-counter plus the free-running sample-period counter
module adxl_seq_timer #(
    parameter int POWERUP_CYCLES = 1024,
    parameter int SAMPLE_PERIOD  = 4000
) (
    input  logic        iSPI_CLK,
    input  logic        iRSTN,
    input  logic        load,
    input  logic [15:0] loadVal,
    output logic        expire,
    input  logic        perStart,
    output logic        perExpire
);
    logic [15:0] cnt, perCnt;

    // expire fires on the last counted cycle so a load of N spans exactly N cycles
    assign expire    = cnt == 16'd1;
    assign perExpire = perCnt == 16'd1;

    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            cnt    <= 16'(POWERUP_CYCLES);
            perCnt <= '0;
        end else begin
            cnt    <= load ? loadVal : (cnt != '0 ? cnt - 16'd1 : cnt);
            perCnt <= (perStart || perExpire) ? 16'(SAMPLE_PERIOD) : (perCnt != '0 ? perCnt - 16'd1 : perCnt);
        end
    end
endmodule

// File: rtl/adxl_spi_sequencer.sv
// adxl_spi_sequencer: drives the 3-wire SPI engine through ADXL345 init writes and periodic X/Y/Z read bursts
module adxl_spi_sequencer #(
    parameter int POWERUP_CYCLES = 1024,
    parameter int GAP_CYCLES     = 4,
    parameter int SAMPLE_PERIOD  = 4000,
    parameter int XFER_TIMEOUT   = 32
) (
    input  logic        iSPI_CLK,
    input  logic        iRSTN,
    input  logic        iENABLE,
    output logic [15:0] oP2S_DATA,
    output logic        oSPI_GO,
    input  logic        iSPI_END,
    input  logic [7:0]  iS2P_DATA,
    output logic [15:0] oX,
    output logic [15:0] oY,
    output logic [15:0] oZ,
    output logic        oDATA_VALID,
    output logic        oINIT_DONE,
    output logic        oERR
);
    import adxl_seq_pkg::*;

    localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES);
    localparam logic [15:0] TO_LD  = 16'(XFER_TIMEOUT);

    seqState_t   state, next;
    logic [2:0]  idx, nIdx;
    logic [15:0] tVal;
    logic        tLoad, tExp, perStart, perExp, timeout, enterXfer;
    logic [7:0]  rdBuf [RD_LEN];

    adxl_seq_timer #(.POWERUP_CYCLES(POWERUP_CYCLES), .SAMPLE_PERIOD(SAMPLE_PERIOD)) uTimer (
        .iSPI_CLK (iSPI_CLK),
        .iRSTN    (iRSTN),
        .load     (tLoad),
        .loadVal  (tVal),
        .expire   (tExp),
        .perStart (perStart),
        .perExpire(perExp)
    );

    assign timeout   = (state == INIT_XFER || state == RD_XFER) && tExp && !iSPI_END;
    assign enterXfer = (next == INIT_XFER || next == RD_XFER) && next != state;

    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) state <= PWRUP;
        else        state <= next;
    end

    always_comb begin
        next     = state;
        nIdx     = idx;
        tLoad    = 1'b0;
        tVal     = TO_LD;
        perStart = 1'b0;
        case (state)
            PWRUP: if (tExp) begin
                next  = INIT_XFER;
                nIdx  = '0;
                tLoad = 1'b1;
            end
            INIT_XFER: if (iSPI_END || tExp) begin
                next  = INIT_GAP;
                tLoad = 1'b1;
                tVal  = GAP_LD;
            end
            INIT_GAP: if (tExp) begin
                if (idx == 3'(INIT_LEN - 1)) begin
                    next     = WAIT;
                    perStart = 1'b1;
                end else begin
                    next  = INIT_XFER;
                    nIdx  = idx + 3'd1;
                    tLoad = 1'b1;
                end
            end
            WAIT: if (perExp && iENABLE) begin
                next  = RD_XFER;
                nIdx  = '0;
                tLoad = 1'b1;
            end
            // a timed-out read skips RD_CAP so its slot keeps the previous byte
            RD_XFER: if (iSPI_END) next = RD_CAP;
            else if (tExp) begin
                next  = RD_GAP;
                tLoad = 1'b1;
                tVal  = GAP_LD;
            end
            RD_CAP: begin
                next  = RD_GAP;
                tLoad = 1'b1;
                tVal  = GAP_LD;
            end
            RD_GAP: if (tExp) begin
                if (idx == 3'(RD_LEN - 1)) next = EMIT;
                else begin
                    next  = RD_XFER;
                    nIdx  = idx + 3'd1;
                    tLoad = 1'b1;
                end
            end
            EMIT:    next = WAIT;
            default: next = PWRUP;
        endcase
    end

    // GO follows the next state, so it drops on the very edge that sees END
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            idx         <= '0;
            oSPI_GO     <= 1'b0;
            oP2S_DATA   <= '0;
            oX          <= '0;
            oY          <= '0;
            oZ          <= '0;
            oDATA_VALID <= 1'b0;
            oINIT_DONE  <= 1'b0;
            oERR        <= 1'b0;
            rdBuf       <= '{default: '0};
        end else begin
            idx     <= nIdx;
            oSPI_GO <= next == INIT_XFER || next == RD_XFER;
            if (enterXfer)
                oP2S_DATA <= next == RD_XFER ? mkFrame(1'b1, RD_ADDR[nIdx], 8'h00)
                                             : mkFrame(1'b0, INIT_ADDR[nIdx[1:0]], INIT_DATA[nIdx[1:0]]);
            if (state == RD_CAP) rdBuf[idx] <= iS2P_DATA;
            if (next == EMIT) begin
                oX <= {rdBuf[1], rdBuf[0]};
                oY <= {rdBuf[3], rdBuf[2]};
                oZ <= {rdBuf[5], rdBuf[4]};
            end
            oDATA_VALID <= next == EMIT;
            oINIT_DONE  <= oINIT_DONE | perStart;
            oERR        <= oERR | timeout;
        end
    end
endmodule

// File: tb/tb_adxl_spi_sequencer.sv
// tb_adxl_spi_sequencer: behavioural SPI engine plus table-driven burst vectors and directed init/timeout/reset sequences
module tb_adxl_spi_sequencer;
    localparam int PWR = 64;
    localparam int GAP = 4;
    localparam int PER = 400;
    localparam int TO  = 32;
    localparam logic [15:0] INIT_F [3] = '{16'h3140, 16'h2C0A, 16'h2D08};

    logic clk = 1'b0, rstn = 1'b0, en = 1'b0;
    logic spiEnd, go, valid, initDone, err;
    logic [7:0] s2p;
    logic [15:0] p2s, x, y, z;

    adxl_spi_sequencer #(.POWERUP_CYCLES(PWR), .GAP_CYCLES(GAP), .SAMPLE_PERIOD(PER), .XFER_TIMEOUT(TO)) dut (
        .iSPI_CLK(clk), .iRSTN(rstn), .iENABLE(en), .oP2S_DATA(p2s), .oSPI_GO(go),
        .iSPI_END(spiEnd), .iS2P_DATA(s2p), .oX(x), .oY(y), .oZ(z),
        .oDATA_VALID(valid), .oINIT_DONE(initDone), .oERR(err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [6];
    logic       late = 1'b0;
    int         dropIdx = -1;
    logic       busy, lateQ;
    logic [7:0] pend;
    int         mcnt, txn;

    function automatic logic [7:0] rdByte(input logic [15:0] f);
        int a;
        a = int'(f[13:8]) - 'h32;
        return (f[15] && a >= 0 && a < 6) ? mem[a] : 8'h00;
    endfunction

    // engine: END 16 cycles after GO rise; in late mode the byte only becomes valid after END
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spiEnd <= 1'b0; s2p <= '0; busy <= 1'b0; lateQ <= 1'b0; pend <= '0; mcnt <= 0; txn <= 0;
        end else begin
            spiEnd <= 1'b0;
            if (lateQ) begin s2p <= pend; lateQ <= 1'b0; end
            if (!go) busy <= 1'b0;
            else if (!busy) begin busy <= 1'b1; mcnt <= 1; txn <= txn + 1; end
            else begin
                mcnt <= mcnt + 1;
                if (mcnt == 15 && txn - 1 != dropIdx) begin
                    spiEnd <= 1'b1;
                    if (late) begin s2p <= 8'hA5; pend <= rdByte(p2s); lateQ <= 1'b1; end
                    else s2p <= rdByte(p2s);
                end
            end
        end
    end

    logic [15:0] frames [$];
    int hiLens [$], loLens [$];
    logic goQ = 1'b0, endQ = 1'b0, validQ = 1'b0;
    logic [15:0] p2sQ = '0;
    int hi = 0, lo = 0, unstable = 0, goAfterEnd = 0, longValid = 0;

    always @(negedge clk) begin
        if (go && !goQ) begin frames.push_back(p2s); loLens.push_back(lo); end
        if (!go && goQ) hiLens.push_back(hi);
        if (go && goQ && p2s != p2sQ) unstable <= unstable + 1;
        if (go && endQ) goAfterEnd <= goAfterEnd + 1;
        if (valid && validQ) longValid <= longValid + 1;
        hi <= go ? (goQ ? hi + 1 : 1) : 0;
        lo <= go ? 0 : (goQ ? 1 : lo + 1);
        goQ <= go; endQ <= spiEnd; validQ <= valid; p2sQ <= p2s;
    end

    int nChk = 0, nFail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int s);
        return s == 0 ? valid : (s == 1 ? go : initDone);
    endfunction

    task automatic waitSig(input int s, input int lim, input string name, output int n);
        n = 0;
        while (n < lim) begin
            @(negedge clk);
            n++;
            if (sig(s)) break;
        end
        chk(name, 32'(sig(s)), 1);
    endtask

    task automatic checkInit(input int base, input int toIdx);
        chk("init_count", frames.size() - base, 3);
        for (int i = 0; i < 3 && base + i < frames.size() && base + i < hiLens.size(); i++) begin
            chk($sformatf("init_frame%0d", i), frames[base + i], INIT_F[i]);
            chk($sformatf("init_go_len%0d", i), hiLens[base + i], i == toIdx ? TO : 17);
            if (i > 0) chk($sformatf("init_gap%0d", i), loLens[base + i], GAP);
        end
    endtask

    typedef struct packed {
        logic        late;
        logic        dropEn;
        logic [47:0] bytes;
        logic [15:0] ex, ey, ez;
    } vec_t;
    vec_t vecs [4];

    initial begin
        int n, gap, fcnt, base;
        vecs[0] = '{1'b0, 1'b0, 48'h80FF_4433_2211, 16'h2211, 16'h4433, 16'h80FF};
        vecs[1] = '{1'b1, 1'b0, 48'h0605_0403_0201, 16'h0201, 16'h0403, 16'h0605};
        vecs[2] = '{1'b1, 1'b0, 48'h007F_8000_FFFF, 16'hFFFF, 16'h8000, 16'h007F};
        vecs[3] = '{1'b0, 1'b1, 48'h0000_33CC_55AA, 16'h55AA, 16'h33CC, 16'h0000};
        for (int j = 0; j < 6; j++) mem[j] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_go", 32'(go), 0);
        chk("rst_p2s", 32'(p2s), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_z", 32'(z), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_init_done", 32'(initDone), 0);
        chk("rst_err", 32'(err), 0);
        rstn = 1'b1;
        waitSig(2, PWR + 3 * (TO + GAP + 2) + 20, "init_done", n);
        checkInit(0, -1);
        chk("init_err", 32'(err), 0);
        repeat (3 * PER + 50) @(negedge clk);
        chk("disabled_no_go", frames.size(), 3);
        gap = 0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 6; j++) mem[j] = vecs[r].bytes[j * 8 +: 8];
            late = vecs[r].late;
            if (r == 0) begin
                en = 1'b1;
                waitSig(1, 2 * PER, "first_burst_go", n);
                chk("first_burst_delay", n, PER - 50);
            end else if (vecs[r].dropEn) begin
                waitSig(1, 2 * PER, "burst_go", n);
                en = 1'b0;
                gap += n;
            end
            waitSig(0, 2 * PER, $sformatf("row%0d_valid", r), n);
            gap += n;
            chk($sformatf("row%0d_x", r), 32'(x), 32'(vecs[r].ex));
            chk($sformatf("row%0d_y", r), 32'(y), 32'(vecs[r].ey));
            chk($sformatf("row%0d_z", r), 32'(z), 32'(vecs[r].ez));
            if (r > 0) chk($sformatf("row%0d_period", r), gap, PER);
            @(negedge clk);
            chk($sformatf("row%0d_valid_pulse", r), 32'(valid), 0);
            gap = 1;
        end
        fcnt = frames.size();
        repeat (PER + 10) @(negedge clk);
        chk("disabled_after_burst", frames.size(), fcnt);
        en = 1'b1;
        waitSig(1, 2 * PER, "rd_go", n);
        chk("rd_frame0", 32'(p2s), 32'h0000B200);
        repeat (7) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_go", 32'(go), 0);
        chk("mid_rst_p2s", 32'(p2s), 0);
        chk("mid_rst_x", 32'(x), 0);
        chk("mid_rst_y", 32'(y), 0);
        chk("mid_rst_z", 32'(z), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_init_done", 32'(initDone), 0);
        chk("mid_rst_err", 32'(err), 0);
        dropIdx = 1;
        repeat (2) @(negedge clk);
        base = frames.size();
        rstn = 1'b1;
        waitSig(2, PWR + 3 * (TO + GAP + 2) + 20, "reinit_done", n);
        checkInit(base, 1);
        chk("timeout_err", 32'(err), 1);
        chk("go_after_end", goAfterEnd, 0);
        chk("p2s_stable", unstable, 0);
        chk("valid_width", longValid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule

// File: doc/adxl_spi_sequencer.md
# adxl_spi_sequencer

Sequences the 3-wire SPI transaction engine for the ADXL345 glove accelerometer. After reset it writes a fixed register-initialisation table, then periodically issues six single-byte reads (DATAX0..DATAZ1) and presents assembled signed 16-bit X/Y/Z samples with a valid strobe. It is the only master of the engine's host side: `iP2S_DATA`, `iSPI_GO`, `oSPI_END` and `oS2P_DATA`.

## Interface
Parameters:
- `POWERUP_CYCLES`, 1024: idle cycles after reset before the first transaction.
- `GAP_CYCLES`, 4: chip-select-high cycles between transactions; minimum 1.
- `SAMPLE_PERIOD`, 4000: cycles from one sample-burst start to the next; must exceed 6*(17+`GAP_CYCLES`+1).
- `XFER_TIMEOUT`, 32: cycles allowed from `oSPI_GO` rise to `iSPI_END`.

Ports:
- `iSPI_CLK`, in, 1: clock, same clock as the engine.
- `iRSTN`, in, 1: reset, asynchronous, active-low.
- `iENABLE`, in, 1: permits new sample bursts; init runs regardless.
- `oP2S_DATA`, out, 16: frame to the engine. Bit 15 is R/W (1 = read), bit 14 is MB (always 0), bits 13:8 are the address, bits 7:0 are the write data.
- `oSPI_GO`, out, 1: transaction request / chip-select enable to the engine.
- `iSPI_END`, in, 1: one-cycle transaction-complete pulse from the engine.
- `iS2P_DATA`, in, 8: read byte from the engine.
- `oX`, `oY`, `oZ`, out, 16 each: signed samples (`{DATAx1, DATAx0}`).
- `oDATA_VALID`, out, 1: one-cycle strobe; X/Y/Z updated.
- `oINIT_DONE`, out, 1: level; init table completed.
- `oERR`, out, 1: sticky; a transaction timeout occurred.

## Operation
- Reset values: `oSPI_GO`=0, `oP2S_DATA`=0, `oX`/`oY`/`oZ`=0, `oDATA_VALID`=0, `oINIT_DONE`=0, `oERR`=0, state=PWRUP.
- Init table, in order:
  - 0x31 ← 0x40 (DATA_FORMAT: 3-wire SPI)
  - 0x2C ← 0x0A (BW_RATE: 100 Hz)
  - 0x2D ← 0x08 (POWER_CTL: measure)
- Read list: 0x32 to 0x37, each as a single-byte read (frame `{1'b1, 1'b0, addr, 8'h00}`).
- States and transitions:
  - PWRUP → INIT_XFER after `POWERUP_CYCLES`.
  - INIT_XFER → INIT_GAP on END.
  - INIT_GAP → INIT_XFER (next entry) or WAIT (table done; set `oINIT_DONE`).
  - WAIT → RD_XFER when the period counter expires and `iENABLE`=1.
  - RD_XFER → RD_CAP on END.
  - RD_CAP → RD_GAP.
  - RD_GAP → RD_XFER (index < 5) or EMIT.
  - EMIT → WAIT.
- `oP2S_DATA` is loaded on XFER entry and held stable until END.
- RD_CAP stores `iS2P_DATA` into byte slot [index].
- EMIT copies all six bytes to `oX`/`oY`/`oZ` atomically and pulses `oDATA_VALID`.
- The period counter is free-running from the first WAIT entry and reloads on expiry. An expiry with `iENABLE`=0 is discarded; the burst waits for the next expiry.
- `iENABLE` deasserted mid-burst: the burst completes and emits.
- Timeout: END absent within `XFER_TIMEOUT` cycles of GO rise. Response: set `oERR`, drop GO, go to the GAP state and continue the sequence. A timed-out read slot keeps its previous byte.
- `iRSTN` asserted mid-transaction: GO drops immediately (asynchronous), and init restarts from PWRUP.

## Timing
- GO rises on XFER entry. END is expected 16 cycles later.
- GO is cleared on the edge where END=1. GO must never be high in the cycle after END; otherwise the engine re-arms.
- `iS2P_DATA` is final only one cycle after END. It is captured in RD_CAP, never on the END cycle.
- GAP holds GO low for exactly `GAP_CYCLES` cycles.
- Per read transaction: 17 (GO) + 1 (CAP) + `GAP_CYCLES` cycles.
- `oDATA_VALID` asserts in the cycle after the last RD_GAP ends.

## Structure
- Package `adxl_seq_pkg`:
  - state enum
  - register address constants (0x2C, 0x2D, 0x31, 0x32..0x37)
  - init table as constant arrays `INIT_ADDR[3]` / `INIT_DATA[3]`
  - frame-builder function
- One sub-module: `adxl_seq_timer`, a shared down-counter used for power-up, gap and timeout with a load/expire interface, plus the separate sample-period counter.

## Test plan
- Reset release with a behavioural engine model (END 16 cycles after GO) → frames 0x3140, 0x2C0A, 0x2D08 in order, each GO high 17 cycles, gaps of 4 cycles; then `oINIT_DONE`=1.
- Read data bytes 0x11,0x22,0x33,0x44,0xFF,0x80 for 0x32..0x37 → `oX`=0x2211, `oY`=0x4433, `oZ`=0x80FF (−32513), one-cycle `oDATA_VALID`.
- Model asserts END but updates `iS2P_DATA` one cycle late → captured values still correct; a capture on the END cycle must fail this test.
- Model never asserts END on the second init write → `oERR`=1 after 32 cycles, GO low, sequence proceeds to the third write.
- `iENABLE`=0 after init → no GO for 3 periods. Raise it → the burst starts at the next period expiry, and successive bursts start `SAMPLE_PERIOD` cycles apart.
- `iRSTN` pulsed low at the 8th cycle of a read → GO=0 asynchronously, outputs at reset values, init table replays from 0x3140.
